// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
//   NUM_RD asynchronous read ports, two synchronous write ports (port 1 wins
//   on an address collision), optional hardwired-zero entry 0, and a debug
//   tap (a0) on entry DBG_REG. After reset a sequential engine clears every
//   entry, one per cycle, before the file reports ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_addr / rd_data   packed read ports, port i at [i*W +: W]
//   we0/wa0/wd0         write port 0
//   we1/wa1/wd1         write port 1 (higher priority)
//   ready               high once the clear sequence has completed
//   a0                  stored contents of entry DBG_REG
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
module regfile_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned HARD_ZERO  = 1,
    parameter int unsigned DBG_REG    = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    input  logic                           we0,
    input  logic [ADDR_WIDTH-1:0]          wa0,
    input  logic [DATA_WIDTH-1:0]          wd0,
    input  logic                           we1,
    input  logic [ADDR_WIDTH-1:0]          wa1,
    input  logic [DATA_WIDTH-1:0]          wd1,
    output logic                           ready,
    output logic [DATA_WIDTH-1:0]          a0
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DBG_IDX  = ADDR_WIDTH'(DBG_REG);
    localparam logic                  HZ       = (HARD_ZERO != 0);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clear_cnt_q, clear_cnt_d;
    logic                    ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

    logic                    clear_we_c;
    logic                    run_we_c;
    logic                    wr0_ok_c;
    logic                    wr1_ok_c;

    // Writes only take effect on an edge not sampled with rst high.
    assign clear_we_c = (state_q == S_CLEAR) && !rst;
    assign run_we_c   = (state_q == S_RUN) && !rst;
    assign wr0_ok_c   = run_we_c && we0 && !(HZ && (wa0 == '0));
    assign wr1_ok_c   = run_we_c && we1 && !(HZ && (wa1 == '0));

    // State register; the array has no reset and holds while rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            clear_cnt_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
            ready_q     <= ready_d;
        end
        mem_q <= mem_d;
    end

    // Next-state: walk clear_cnt over every entry, then move to RUN.
    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        case (state_q)
            S_CLEAR: begin
                clear_cnt_d = clear_cnt_q + ADDR_WIDTH'(1);
                if (clear_cnt_q == LAST_IDX) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
        ready_d = (state_d == S_RUN);
    end

    // Array update; port 1 is applied last so it wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        if (clear_we_c) begin
            mem_d[clear_cnt_q] = '0;
        end
        if (wr0_ok_c) begin
            mem_d[wa0] = wd0;
        end
        if (wr1_ok_c) begin
            mem_d[wa1] = wd1;
        end
    end

    // Read ports: combinational lookup, optional bypass, zero rules.
    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_c;
        logic [DATA_WIDTH-1:0] rv_c;

        assign ra_c = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rv_c = mem_q[ra_c];
`ifdef REGFILE_BYPASS_EN
            if (wr1_ok_c && (wa1 == ra_c)) begin
                rv_c = wd1;
            end else if (wr0_ok_c && (wa0 == ra_c)) begin
                rv_c = wd0;
            end
`endif
            if (HZ && (ra_c == '0)) begin
                rv_c = '0;
            end
            if (state_q != S_RUN) begin
                rv_c = '0;
            end
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rv_c;
    end

    // Debug tap shows stored contents only, never bypassed.
    assign a0 = ((state_q == S_RUN) && !(HZ && (DBG_IDX == '0))) ? mem_q[DBG_IDX] : '0;

    assign ready = ready_q;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the RISC-V core. It provides NUM_RD asynchronous read ports and two synchronous write ports with fixed priority. Register 0 can be hardwired to zero, and a selectable debug register drives the a0 output. After reset, a sequential clear engine zeroes every entry. The block replaces the single-write, two-read register file between decode and the ALU/writeback stages.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries.
- NUM_RD, 2, number of read ports (1–4).
- HARD_ZERO, 1, when 1 entry 0 always reads 0 and writes to it are discarded.
- DBG_REG, 10, index of the register driven on a0.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data, same packing as rd_addr.
- we0  in  1  write enable, port 0.
- wa0  in  ADDR_WIDTH  write address, port 0.
- wd0  in  DATA_WIDTH  write data, port 0.
- we1  in  1  write enable, port 1 (higher priority).
- wa1  in  ADDR_WIDTH  write address, port 1.
- wd1  in  DATA_WIDTH  write data, port 1.
- ready  out  1  high once the clear sequence has completed.
- a0  out  DATA_WIDTH  contents of register DBG_REG.

## Operation
- The FSM has two states, CLEAR and RUN. clear_cnt is ADDR_WIDTH bits wide.
- While rst is high:
  - state = CLEAR and clear_cnt = 0.
  - Array contents are left unchanged.
- In CLEAR with rst low, each edge:
  - writes mem[clear_cnt] <= 0 and increments clear_cnt;
  - when clear_cnt == DEPTH-1, that write is performed and the state moves to RUN.
- In CLEAR, we0/we1 are ignored. rd_data and a0 are forced to 0.
- In RUN:
  - if we0 is high, mem[wa0] <= wd0;
  - if we1 is high, mem[wa1] <= wd1;
  - if both are high with wa0 == wa1, only wd1 is stored.
- HARD_ZERO=1: writes with address 0 are dropped, and reads of address 0 return 0 regardless of storage.
- Reads are combinational: rd_data[i] = mem[rd_addr[i]], subject to the bypass and zero rules.
- a0 = mem[DBG_REG]. a0 is never bypassed, so it reflects the stored value only.
- Asserting rst in RUN restarts the clear sequence and drops ready on the next edge. Writes presented in the same cycle as rst are discarded.

## Timing
- Reset values: ready = 0, rd_data = 0, a0 = 0, state = CLEAR, clear_cnt = 0.
- ready rises exactly DEPTH edges after the first edge sampled with rst low (32 edges at defaults).
- Write latency: data written at edge N is visible on rd_data (no bypass) and on a0 from just after edge N.
- Read latency: zero cycles. rd_data follows rd_addr combinationally.
- All ports read independently; no arbitration is needed for reads.

## Configuration
- REGFILE_BYPASS_EN:
  - Defined: in RUN, if rd_addr[i] matches an enabled write address in the same cycle, rd_data[i] returns that write data. wd1 has precedence over wd0. HARD_ZERO still forces 0 for address 0.
  - Not defined: rd_data[i] returns the stored value. The new value appears after the edge.

## Test plan
- Reset then clear:
  - Hold rst for 3 cycles, release, and count edges: ready = 0 for 32 edges, then 1.
  - Every address then reads 0 and a0 = 0.
- Basic write/read:
  - we0, wa0 = 5, wd0 = 0xDEADBEEF at edge N; rd_addr[0] = 5 after N reads 0xDEADBEEF.
  - we1, wa1 = 10, wd1 = 0x1234 makes a0 = 0x00001234.
- Collision:
  - we0 = we1 = 1, wa0 = wa1 = 7, wd0 = 0x1, wd1 = 0x2; reading address 7 afterwards returns 0x2.
  - Independent addresses 3 and 4 in one cycle both land.
- Zero register:
  - HARD_ZERO=1: write 0xFFFFFFFF to address 0; reads return 0.
  - HARD_ZERO=0: the same read returns 0xFFFFFFFF.
- Bypass:
  - rd_addr[1] = 9, mem[9] = 0x11; same-cycle write wa0 = 9, wd0 = 0x22.
  - rd_data[1] = 0x22 in that cycle with REGFILE_BYPASS_EN, 0x11 without; 0x22 in both builds after the edge.
- Reset mid-operation:
  - Write 0x55 to address 10, assert rst for 1 cycle with we0 = 1, wa0 = 10, wd0 = 0x77.
  - ready drops; writes during CLEAR are ignored; after 32 edges ready = 1 and a0 = 0.
